// File: rtl/mcu_block_arbiter_if.sv
// AXI4-Stream bundle shared by the DCT pipelines, the block arbiter and the zig-zag stage.
interface axi4_stream_if #(
  parameter int TDATA_W = 16
) ();
  logic               tvalid;
  logic               tready;
  logic [TDATA_W-1:0] tdata;
  logic [TDATA_W/8-1:0] tstrb;
  logic [TDATA_W/8-1:0] tkeep;
  logic               tlast;
  logic               tuser;

  modport master (output tvalid, tdata, tstrb, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tstrb, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/mcu_block_arbiter.sv
// Interleaves Y/Cb/Cr 64-beat DCT blocks in JPEG MCU order onto one stream,
// tagging each beat with its component id.
module mcu_block_arbiter #(
  parameter  int DCT_WIDTH       = 12,
  localparam int DCT_TDATA_WIDTH = ((DCT_WIDTH + 7) / 8) * 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          mode_i,
  axi4_stream_if.slave  y_i,
  axi4_stream_if.slave  cb_i,
  axi4_stream_if.slave  cr_i,
  axi4_stream_if.master mcu_o,
  output logic [1:0]    comp_o,
  output logic          err_o
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state;
  logic [5:0]  r_beat_cnt;
  logic [5:0]  r_drop_cnt;
  logic [2:0]  r_slot_cnt;
  logic        r_mode_q;
  logic        r_err;

  logic [1:0]                 w_comp;
  logic                       w_vld;
  logic [DCT_TDATA_WIDTH-1:0] w_data;
  logic                       w_user;
  logic                       w_last;
  logic                       w_out_vld;
  logic                       w_xfer;
  logic                       w_first;
  logic                       w_eof;
  logic                       w_beat63;
  logic                       w_drop;
  logic                       w_err;
  logic [2:0]                 w_wrap;

  // Slot -> component; IDLE always looks at Y waiting for a frame start.
  always_comb begin
    w_comp = 2'd0;
    if (r_state == S_RUN) begin
      if (!r_mode_q)             w_comp = r_slot_cnt[1:0];
      else if (r_slot_cnt < 3'd4) w_comp = 2'd0;
      else if (r_slot_cnt == 3'd4) w_comp = 2'd1;
      else                        w_comp = 2'd2;
    end
  end

  always_comb begin
    w_vld  = y_i.tvalid;
    w_data = y_i.tdata;
    w_user = y_i.tuser;
    w_last = y_i.tlast;
    case (w_comp)
      2'd1: begin
        w_vld  = cb_i.tvalid;
        w_data = cb_i.tdata;
        w_user = cb_i.tuser;
        w_last = cb_i.tlast;
      end
      2'd2: begin
        w_vld  = cr_i.tvalid;
        w_data = cr_i.tdata;
        w_user = cr_i.tuser;
        w_last = cr_i.tlast;
      end
      default: ;
    endcase
  end

  assign w_beat63  = (r_beat_cnt == 6'd63);
  assign w_wrap    = r_mode_q ? 3'd5 : 3'd2;
  // A Y beat 0 carrying tuser starts a frame, both from IDLE and as a restart in RUN.
  assign w_first   = (w_comp == 2'd0) && w_user && (r_beat_cnt == 6'd0);
  assign w_eof     = (w_comp == 2'd2) && w_beat63 && w_last;
  assign w_drop    = (r_state == S_IDLE) && y_i.tvalid && !y_i.tuser && !rst_i;
  assign w_out_vld = !rst_i && ((r_state == S_IDLE) ? (y_i.tvalid && y_i.tuser) : w_vld);
  assign w_xfer    = w_out_vld && mcu_o.tready;

  assign w_err = (w_drop && (r_drop_cnt == 6'd0))
              || (w_xfer && (r_state == S_RUN) && w_user)
              || (w_xfer && w_last && !w_eof);

  // Headerless Y beats in IDLE are swallowed so a broken frame cannot stall the Y pipe.
  assign y_i.tready  = !rst_i && (w_comp == 2'd0) &&
                       ((r_state == S_IDLE) ? (y_i.tuser ? mcu_o.tready : y_i.tvalid) : mcu_o.tready);
  assign cb_i.tready = !rst_i && (w_comp == 2'd1) && mcu_o.tready;
  assign cr_i.tready = !rst_i && (w_comp == 2'd2) && mcu_o.tready;

  assign mcu_o.tvalid = w_out_vld;
  assign mcu_o.tdata  = w_data;
  assign mcu_o.tuser  = w_first;
  assign mcu_o.tlast  = w_eof;
  assign mcu_o.tstrb  = '1;
  assign mcu_o.tkeep  = '1;
  assign comp_o       = w_comp;
  assign err_o        = r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_beat_cnt <= '0;
      r_drop_cnt <= '0;
      r_slot_cnt <= '0;
      r_mode_q   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_err;
      case (r_state)
        S_IDLE: begin
          if (w_drop) r_drop_cnt <= r_drop_cnt + 6'd1;
          if (w_xfer) begin
            r_state    <= S_RUN;
            r_mode_q   <= mode_i;
            r_beat_cnt <= 6'd1;
            r_slot_cnt <= '0;
            r_drop_cnt <= '0;
          end
        end
        default: begin
          if (w_xfer) begin
            if (w_first) begin
              r_slot_cnt <= '0;
              r_mode_q   <= mode_i;
              r_beat_cnt <= 6'd1;
            end else if (w_beat63) begin
              r_beat_cnt <= '0;
              if (w_eof) begin
                r_state    <= S_IDLE;
                r_slot_cnt <= '0;
              end else begin
                r_slot_cnt <= (r_slot_cnt == w_wrap) ? 3'd0 : r_slot_cnt + 3'd1;
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + 6'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/mcu_block_arbiter.md
Name: mcu_block_arbiter

Overview:
- Shares the single zig-zag/quantizer path between three per-component DCT block streams (Y, Cb, Cr).
- Grants whole 64-coefficient blocks in JPEG MCU order: 4:4:4 order is Y,Cb,Cr; 4:2:0 order is Y,Y,Y,Y,Cb,Cr.
- Tags each beat with a component id, which downstream uses for quant/Huffman table selection.
- Sits between the three DCT pipelines and the zig-zag block.

Parameters:
DCT_WIDTH, 12, coefficient width; stream tdata width = DCT_WIDTH rounded up to a multiple of 8.

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
mode_i  input  1  0 = 4:4:4, 1 = 4:2:0; sampled at frame start only
y_i  axi4_stream_if.slave  tdata DCT_TDATA_WIDTH  Y blocks, 64 beats each; tuser = first beat of frame
cb_i  axi4_stream_if.slave  same  Cb blocks
cr_i  axi4_stream_if.slave  same  Cr blocks; tlast = last beat of last block of frame
mcu_o  axi4_stream_if.master  same  interleaved blocks to zig-zag
comp_o  output  2  component id of current mcu_o beat: 0 = Y, 1 = Cb, 2 = Cr; valid with mcu_o.tvalid
err_o  output  1  one-cycle pulse on protocol error

Behaviour:
- Reset values: state IDLE, beat_cnt 0, slot_cnt 0, mode_q 0, err_o 0, comp_o 0. All slave tready = 0; mcu_o.tvalid = 0.
- Datapath: combinational mux of the granted slave onto mcu_o (0-cycle latency).
  - mcu_o.tvalid = granted tvalid; granted tready = mcu_o.tready.
  - Non-granted tready = 0.
  - tstrb/tkeep = all ones.
- Handshake rule: a beat transfers when granted tvalid && mcu_o.tready. Counters advance only on a transfer.
- State IDLE:
  - Grant Y, but y_i.tready = mcu_o.tready && y_i.tuser. Y beats without tuser are dropped with tready = 1, and err_o pulses once per dropped block start.
  - On a Y transfer with tuser: latch mode_q = mode_i, go to RUN, beat_cnt = 1.
- State RUN:
  - beat_cnt counts 0..63 within the granted block.
  - On the transfer with beat_cnt = 63:
    - slot_cnt advances. Wrap point is 2 in 4:4:4 and 5 in 4:2:0; wrap returns to 0.
    - Grant switches for the very next cycle, with no bubble.
  - Slot to component map:
    - 4:4:4: slot 0 = Y, 1 = Cb, 2 = Cr.
    - 4:2:0: slots 0–3 = Y, 4 = Cb, 5 = Cr.
  - If the Cr beat 63 transfer has cr_i.tlast = 1: go to IDLE, slot_cnt = 0, beat_cnt = 0.
- Sideband:
  - mcu_o.tuser = y_i.tuser on the first beat of the frame only. Any tuser elsewhere is masked to 0 and pulses err_o.
  - mcu_o.tlast = cr_i.tlast only on Cr beat 63. tlast on Y/Cb, or on any other beat, is masked to 0 and pulses err_o.
- Boundary conditions:
  - Early or off-order valid (e.g. Cb valid during a Y slot): the stream is held by tready = 0. No data is lost and no error is raised.
  - mode_i change mid-frame: ignored until the next IDLE → RUN transition.
  - Y tuser arriving at beat 0 of a Y slot while in RUN (frame restart):
    - Accepted as a new frame start; err_o pulses.
    - slot_cnt = 0 and mode_q re-latched.
    - The beat transfers as frame beat 0.
  - mcu_o.tready low at beat 63: grant and counters hold until the transfer.
  - Reset mid-block: immediate return to reset values. The partial block is not completed. Upstream DCT and zig-zag are reset by the same rst_i.

Test Plan:
- mode_i = 0; one MCU frame of ramp data (Y 0..63, Cb 100..163, Cr 200..263) with Cr tlast → mcu_o carries 192 beats in order Y, Cb, Cr.
  - comp_o is 0/1/2; tuser is on beat 0 only; tlast is on beat 191 only; no idle cycles when all streams are valid.
- mode_i = 1; four Y blocks, Cb, Cr, then a second MCU ending with tlast → component sequence 0,0,0,0,1,2,0,0,0,0,1,2 per block; tlast on the final beat; state returns to IDLE.
- Cb and Cr streams valid from cycle 0 while Y is granted → cb_i.tready and cr_i.tready stay 0 until their slot; data arrives intact.
- Random mcu_o.tready at 50% duty and random input tvalid gaps → output beat sequence is identical to the no-stall run.
- mode_i toggled mid-frame in 4:4:4 → ordering unchanged; the new mode takes effect only at the next frame's tuser.
- Y tuser injected at the start of the second Y block of a 4:2:0 frame → err_o pulses one cycle; slot_cnt restarts at 0; mcu_o.tuser = 1 on that beat.
- rst_i asserted at beat 30 of a Cb block → all tready and tvalid drop to 0 in the same cycle.
  - After release, only a Y beat with tuser starts output.
